// File: rtl/mem_reset_drain.sv
// mem_reset_drain
// Quiesces AXI read/write request traffic toward the DDR controller before a
// memory reset, drives the reset request, and reopens traffic once the memory
// reports ready again. Lives entirely in the memory controller clock domain.
//
// Optional feature macro: MEM_RESET_DRAIN_TIMEOUT_EN
//   defined   - CLOSE/DRAIN are bounded by TIMEOUT_CYCLES; on expiry the
//               block force-closes the gates, enters RESET and sets the sticky
//               drain_timeout flag.
//   undefined - CLOSE/DRAIN wait indefinitely; drain_timeout is tied low.
//
// Handshake semantics (all AR/AW ports): a transfer happens on a rising clock
// edge where valid and ready are both high. Once the upstream master raises
// s_*valid it keeps it high until the handshake, so a gate may only close in a
// cycle where the upstream valid is low or its handshake completes; closing it
// while a request is pending would retract m_*valid illegally.
//
// Debug outputs state_dbg / rd_cnt_dbg / wr_cnt_dbg expose the FSM state and
// the outstanding-transaction counters for checkers.

module mem_reset_drain #(
    parameter int CNT_WIDTH      = 8,
    parameter int RESET_HOLD     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reset_req,
    input  logic                 mem_ok,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    output logic                 m_awvalid,
    input  logic                 m_awready,
    input  logic                 rvalid,
    input  logic                 rready,
    input  logic                 rlast,
    input  logic                 bvalid,
    input  logic                 bready,
    output logic                 mem_sys_reset,
    output logic                 busy,
    output logic                 cnt_error,
    output logic                 drain_timeout,
    output logic [2:0]           state_dbg,
    output logic [CNT_WIDTH-1:0] rd_cnt_dbg,
    output logic [CNT_WIDTH-1:0] wr_cnt_dbg
);

    typedef enum logic [2:0] {
        S_WAIT_OK = 3'd0,
        S_RUN     = 3'd1,
        S_CLOSE   = 3'd2,
        S_DRAIN   = 3'd3,
        S_RESET   = 3'd4
    } state_t;

    // One phase counter serves both the RESET hold time and the drain timeout,
    // so it is sized for the larger of the two.
    localparam int PH_MAX = (RESET_HOLD > TIMEOUT_CYCLES) ? RESET_HOLD : TIMEOUT_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t               state;
    state_t               state_next;

    logic                 ok_meta;
    logic                 ok_sync;

    logic                 ar_open;
    logic                 aw_open;
    logic                 ar_open_next;
    logic                 aw_open_next;

    logic                 ar_hs;
    logic                 aw_hs;
    logic                 rd_done;
    logic                 wr_done;

    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [CNT_WIDTH-1:0] wr_cnt;
    logic [CNT_WIDTH-1:0] rd_cnt_next;
    logic [CNT_WIDTH-1:0] wr_cnt_next;
    logic                 rd_err;
    logic                 wr_err;

    logic [PH_W-1:0]      ph_cnt;
    logic                 hold_done;
    logic                 ok_low_seen;
    logic                 timeout_hit;

    logic                 mem_sys_reset_q;
    logic                 cnt_error_q;

    // ------------------------------------------------------------------
    // Gating and handshake detection
    // ------------------------------------------------------------------
    assign m_arvalid = s_arvalid & ar_open;
    assign s_arready = m_arready & ar_open;
    assign m_awvalid = s_awvalid & aw_open;
    assign s_awready = m_awready & aw_open;

    assign ar_hs   = s_arvalid & m_arready & ar_open;
    assign aw_hs   = s_awvalid & m_awready & aw_open;
    assign rd_done = rvalid & rready & rlast;
    assign wr_done = bvalid & bready;

    assign hold_done = (ph_cnt >= PH_W'(RESET_HOLD - 1));

    // Two-flop synchronizer for the asynchronous memory-ready status.
    always_ff @(posedge clock) begin
        if (reset) begin
            ok_meta <= 1'b0;
            ok_sync <= 1'b0;
        end else begin
            ok_meta <= mem_ok;
            ok_sync <= ok_meta;
        end
    end

`ifdef MEM_RESET_DRAIN_TIMEOUT_EN
    logic drain_timeout_q;

    // The phase counter restarts on CLOSE entry and keeps running through
    // DRAIN, so this fires TIMEOUT_CYCLES cycles after CLOSE was entered.
    assign timeout_hit = ((state == S_CLOSE) || (state == S_DRAIN)) &&
                         (ph_cnt == PH_W'(TIMEOUT_CYCLES - 1));

    // Sticky record that a drain was cut short; only the block reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            drain_timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            drain_timeout_q <= 1'b1;
        end
    end

    assign drain_timeout = drain_timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign drain_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Sequence: WAIT_OK -> RUN -> CLOSE -> DRAIN -> RESET -> WAIT_OK.
    always_comb begin
        state_next = state;
        case (state)
            S_WAIT_OK: begin
                if (ok_sync && !reset_req) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (reset_req) begin
                    state_next = S_CLOSE;
                end
            end
            S_CLOSE: begin
                // reset_req is not looked at again: once started, the
                // sequence always runs to completion.
                if (timeout_hit) begin
                    state_next = S_RESET;
                end else if (!ar_open && !aw_open) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (timeout_hit) begin
                    state_next = S_RESET;
                end else if ((rd_cnt == CNT_ZERO) && (wr_cnt == CNT_ZERO)) begin
                    state_next = S_RESET;
                end
            end
            S_RESET: begin
                // The current cycle's low status counts as "seen" so the exit
                // is not delayed by the extra register.
                if (hold_done && (ok_low_seen || !ok_sync)) begin
                    state_next = S_WAIT_OK;
                end
            end
            default: begin
                state_next = S_WAIT_OK;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outstanding-transaction counters
    // ------------------------------------------------------------------
    // Saturating up/down counters; a simultaneous request and completion
    // cancel out, and a completion with nothing outstanding is flagged.
    always_comb begin
        rd_cnt_next = rd_cnt;
        wr_cnt_next = wr_cnt;
        rd_err      = 1'b0;
        wr_err      = 1'b0;

        if (state_next == S_RESET) begin
            rd_cnt_next = CNT_ZERO;
        end else if (ar_hs && !rd_done) begin
            rd_cnt_next = rd_cnt + CNT_WIDTH'(1);
        end else if (!ar_hs && rd_done) begin
            if (rd_cnt == CNT_ZERO) begin
                rd_err = 1'b1;
            end else begin
                rd_cnt_next = rd_cnt - CNT_WIDTH'(1);
            end
        end

        if (state_next == S_RESET) begin
            wr_cnt_next = CNT_ZERO;
        end else if (aw_hs && !wr_done) begin
            wr_cnt_next = wr_cnt + CNT_WIDTH'(1);
        end else if (!aw_hs && wr_done) begin
            if (wr_cnt == CNT_ZERO) begin
                wr_err = 1'b1;
            end else begin
                wr_cnt_next = wr_cnt - CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Gate control
    // ------------------------------------------------------------------
    // In RUN a gate shuts exactly when its counter is about to hit all-ones;
    // that can only happen through a handshake, which is a legal close point,
    // so a counter can never wrap. In CLOSE each gate waits for its upstream
    // valid to go low or be accepted.
    always_comb begin
        ar_open_next = 1'b0;
        aw_open_next = 1'b0;
        case (state)
            S_WAIT_OK: begin
                if (state_next == S_RUN) begin
                    ar_open_next = 1'b1;
                    aw_open_next = 1'b1;
                end
            end
            S_RUN: begin
                ar_open_next = (rd_cnt_next != CNT_MAX);
                aw_open_next = (wr_cnt_next != CNT_MAX);
            end
            S_CLOSE: begin
                if (!timeout_hit) begin
                    ar_open_next = ar_open & s_arvalid & ~ar_hs;
                    aw_open_next = aw_open & s_awvalid & ~aw_hs;
                end
            end
            default: begin
                ar_open_next = 1'b0;
                aw_open_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, gate, counter and flag registers
    // ------------------------------------------------------------------
    // Main control registers; block reset returns to WAIT_OK with gates shut.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_WAIT_OK;
            ar_open         <= 1'b0;
            aw_open         <= 1'b0;
            rd_cnt          <= CNT_ZERO;
            wr_cnt          <= CNT_ZERO;
            mem_sys_reset_q <= 1'b0;
            cnt_error_q     <= 1'b0;
        end else begin
            state           <= state_next;
            ar_open         <= ar_open_next;
            aw_open         <= aw_open_next;
            rd_cnt          <= rd_cnt_next;
            wr_cnt          <= wr_cnt_next;
            mem_sys_reset_q <= (state_next == S_RESET);
            cnt_error_q     <= cnt_error_q | rd_err | wr_err;
        end
    end

    // Phase counter: restarts on entry to CLOSE and to RESET, saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            ph_cnt <= '0;
        end else if (((state_next == S_CLOSE) && (state != S_CLOSE)) ||
                     ((state_next == S_RESET) && (state != S_RESET))) begin
            ph_cnt <= '0;
        end else if (ph_cnt != PH_W'(PH_MAX)) begin
            ph_cnt <= ph_cnt + PH_W'(1);
        end
    end

    // Remembers that memory acknowledged the reset (status low) during RESET.
    always_ff @(posedge clock) begin
        if (reset) begin
            ok_low_seen <= 1'b0;
        end else if (state != S_RESET) begin
            ok_low_seen <= 1'b0;
        end else if (!ok_sync) begin
            ok_low_seen <= 1'b1;
        end
    end

    assign mem_sys_reset = mem_sys_reset_q;
    assign cnt_error     = cnt_error_q;
    assign busy          = (state != S_RUN);
    assign state_dbg     = state;
    assign rd_cnt_dbg    = rd_cnt;
    assign wr_cnt_dbg    = wr_cnt;

endmodule

// File: tb/tb_mem_reset_drain.sv
// Testbench for mem_reset_drain: directed scenarios plus randomized traffic
// checked against a counting model of outstanding reads and writes.

module tb_mem_reset_drain;

    localparam int CW   = 8;
    localparam int HOLD = 16;
    localparam int TMO  = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          reset_req;
    logic          mem_ok;
    logic          s_arvalid;
    logic          s_arready;
    logic          m_arvalid;
    logic          m_arready;
    logic          s_awvalid;
    logic          s_awready;
    logic          m_awvalid;
    logic          m_awready;
    logic          rvalid;
    logic          rready;
    logic          rlast;
    logic          bvalid;
    logic          bready;
    logic          mem_sys_reset;
    logic          busy;
    logic          cnt_error;
    logic          drain_timeout;
    logic [2:0]    state_dbg;
    logic [CW-1:0] rd_cnt_dbg;
    logic [CW-1:0] wr_cnt_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: number of reads / writes issued but not yet completed.
    int model_rd = 0;
    int model_wr = 0;

    mem_reset_drain #(
        .CNT_WIDTH      (CW),
        .RESET_HOLD     (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .reset_req     (reset_req),
        .mem_ok        (mem_ok),
        .s_arvalid     (s_arvalid),
        .s_arready     (s_arready),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .s_awvalid     (s_awvalid),
        .s_awready     (s_awready),
        .m_awvalid     (m_awvalid),
        .m_awready     (m_awready),
        .rvalid        (rvalid),
        .rready        (rready),
        .rlast         (rlast),
        .bvalid        (bvalid),
        .bready        (bready),
        .mem_sys_reset (mem_sys_reset),
        .busy          (busy),
        .cnt_error     (cnt_error),
        .drain_timeout (drain_timeout),
        .state_dbg     (state_dbg),
        .rd_cnt_dbg    (rd_cnt_dbg),
        .wr_cnt_dbg    (wr_cnt_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        m_arready = 1'b1;
        m_awready = 1'b1;
        rvalid    = 1'b0;
        rready    = 1'b1;
        rlast     = 1'b0;
        bvalid    = 1'b0;
        bready    = 1'b1;
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Memory acknowledges reset (status low), then comes back up.
    task automatic recover(output bit ok);
        bit fell;
        fell      = 1'b0;
        mem_ok    = 1'b0;
        reset_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_sys_reset === 1'b0) begin
                fell = 1'b1;
                break;
            end
        end
        mem_ok = 1'b1;
        wait_run(ok);
        ok = ok & fell;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        bit ran;
        reset     = 1'b1;
        reset_req = 1'b0;
        mem_ok    = 1'b1;
        idle_inputs();
        repeat (4) tick();
        n_tests++;
        if (mem_sys_reset !== 1'b0 || busy !== 1'b1 || cnt_error !== 1'b0 || drain_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: msr=%b busy=%b err=%b tmo=%b, required 0 1 0 0",
                     mem_sys_reset, busy, cnt_error, drain_timeout);
        end
        s_arvalid = 1'b1;
        s_awvalid = 1'b1;
        #1;
        n_tests++;
        if ({m_arvalid, m_awvalid, s_arready, s_awready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_gates: m_arv=%b m_awv=%b s_ar=%b s_aw=%b, required all 0",
                     m_arvalid, m_awvalid, s_arready, s_awready);
        end
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        reset     = 1'b0;
        n   = 0;
        ran = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (busy === 1'b0) begin
                ran = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ran || n > 3) begin
            n_fail++;
            $display("FAIL powerup_busy: busy fell=%b after %0d cycles, required by cycle 3", ran, n);
        end
        model_rd = 0;
        model_wr = 0;
    endtask

    task automatic test_passthrough();
        idle_inputs();
        m_arready = 1'b0;
        m_awready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_arvalid = i[0];
            s_awvalid = 1'($urandom_range(0, 1));
            #1;
            n_tests++;
            if (m_arvalid !== s_arvalid || m_awvalid !== s_awvalid || s_arready !== 1'b0) begin
                n_fail++;
                $display("FAIL passthrough_valid: m_arv=%b m_awv=%b s_ar=%b, required %b %b 0",
                         m_arvalid, m_awvalid, s_arready, s_arvalid, s_awvalid);
            end
            tick();
        end
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        m_arready = 1'b1;
        m_awready = 1'b1;
        #1;
        n_tests++;
        if (s_arready !== 1'b1 || s_awready !== 1'b1) begin
            n_fail++;
            $display("FAIL passthrough_ready: s_ar=%b s_aw=%b, required 1 1", s_arready, s_awready);
        end
        tick();
    endtask

    task automatic test_read_drain();
        bit stayed;
        bit fell;
        bit ok;
        idle_inputs();
        s_arvalid = 1'b1;
        repeat (3) tick();
        s_arvalid = 1'b0;
        #1;
        n_tests++;
        if (rd_cnt_dbg !== 8'd3) begin
            n_fail++;
            $display("FAIL drain_rd_cnt3: got %0d, required 3", rd_cnt_dbg);
        end
        reset_req = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_busy: got %b, required 1", busy);
        end
        tick();
        s_arvalid = 1'b1;
        #1;
        n_tests++;
        if (m_arvalid !== 1'b0 || s_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_gate_closed: m_arv=%b s_ar=%b, required 0 0", m_arvalid, s_arready);
        end
        reset_req = 1'b0;
        tick();
        rvalid = 1'b1;
        rlast  = 1'b1;
        repeat (3) tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        n_tests++;
        if (mem_sys_reset !== 1'b0 || rd_cnt_dbg !== 8'd0) begin
            n_fail++;
            $display("FAIL drain_before_reset: msr=%b rd_cnt=%0d, required 0 0", mem_sys_reset, rd_cnt_dbg);
        end
        tick();
        n_tests++;
        if (mem_sys_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_reset_rise: msr=%b, required 1", mem_sys_reset);
        end
        s_arvalid = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_sys_reset !== 1'b1) stayed = 1'b0;
        end
        n_tests++;
        if (!stayed) begin
            n_fail++;
            $display("FAIL reset_held_while_ok: msr dropped while mem_ok=1, required held");
        end
        mem_ok = 1'b0;
        fell   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_sys_reset === 1'b0) begin
                fell = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!fell) begin
            n_fail++;
            $display("FAIL reset_release: msr still %b after mem_ok low, required 0", mem_sys_reset);
        end
        mem_ok = 1'b1;
        wait_run(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_reopen: busy=%b, required 0", busy);
        end
        s_arvalid = 1'b1;
        m_arready = 1'b0;
        #1;
        n_tests++;
        if (m_arvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_reopen_ar: m_arv=%b, required 1", m_arvalid);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_aw_hold();
        bit quiet;
        bit ok;
        int hi;
        idle_inputs();
        s_awvalid = 1'b1;
        m_awready = 1'b0;
        reset_req = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (m_awvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL aw_hold_valid: cycle %0d m_awv=%b, required 1", i, m_awvalid);
            end
        end
        m_awready = 1'b1;
        #1;
        n_tests++;
        if (s_awready !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_hold_ready: s_aw=%b, required 1", s_awready);
        end
        tick();
        #1;
        n_tests++;
        if (m_awvalid !== 1'b0 || wr_cnt_dbg !== 8'd1) begin
            n_fail++;
            $display("FAIL aw_closed_after_hs: m_awv=%b wr_cnt=%0d, required 0 1", m_awvalid, wr_cnt_dbg);
        end
        s_awvalid = 1'b0;
        mem_ok    = 1'b0;
        quiet     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_sys_reset !== 1'b0 || wr_cnt_dbg !== 8'd1) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL aw_wait_b: msr=%b wr_cnt=%0d, required 0 1 until B", mem_sys_reset, wr_cnt_dbg);
        end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        #1;
        n_tests++;
        if (wr_cnt_dbg !== 8'd0) begin
            n_fail++;
            $display("FAIL aw_b_done: wr_cnt=%0d, required 0", wr_cnt_dbg);
        end
        tick();
        hi = (mem_sys_reset === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && hi > 0; i++) begin
            tick();
            if (mem_sys_reset === 1'b1) hi++;
            else break;
        end
        n_tests++;
        if (hi < HOLD || hi > HOLD + 2) begin
            n_fail++;
            $display("FAIL reset_hold_len: high %0d cycles, required %0d..%0d", hi, HOLD, HOLD + 2);
        end
        reset_req = 1'b0;
        mem_ok    = 1'b1;
        wait_run(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL aw_reopen: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_same_cycle_and_error();
        idle_inputs();
        s_arvalid = 1'b1;
        repeat (2) tick();
        rvalid = 1'b1;
        rlast  = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (rd_cnt_dbg !== 8'd2 || cnt_error !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle: rd_cnt=%0d err=%b, required 2 0", rd_cnt_dbg, cnt_error);
        end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        #1;
        n_tests++;
        if (cnt_error !== 1'b1 || wr_cnt_dbg !== 8'd0) begin
            n_fail++;
            $display("FAIL b_underflow: err=%b wr_cnt=%0d, required 1 0", cnt_error, wr_cnt_dbg);
        end
        rvalid = 1'b1;
        rlast  = 1'b1;
        repeat (2) tick();
        idle_inputs();
        #1;
        n_tests++;
        if (rd_cnt_dbg !== 8'd0 || cnt_error !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_cleanup: rd_cnt=%0d err=%b, required 0 1", rd_cnt_dbg, cnt_error);
        end
        model_rd = 0;
        model_wr = 0;
    endtask

    task automatic test_random_traffic();
        bit ar_gate;
        bit aw_gate;
        int rd_inc;
        int rd_dec;
        int wr_inc;
        int wr_dec;
        int bad;
        int guard;
        bit ok;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            s_arvalid = 1'($urandom_range(0, 1));
            m_arready = 1'($urandom_range(0, 1));
            s_awvalid = 1'($urandom_range(0, 1));
            m_awready = 1'($urandom_range(0, 1));
            rvalid    = 1'($urandom_range(0, 1));
            rready    = 1'($urandom_range(0, 1));
            rlast     = 1'($urandom_range(0, 1));
            bvalid    = 1'($urandom_range(0, 1));
            bready    = 1'($urandom_range(0, 1));
            if (model_rd == 0) rlast = 1'b0;
            if (model_wr == 0) bvalid = 1'b0;
            ar_gate = (model_rd != 255);
            aw_gate = (model_wr != 255);
            #1;
            n_tests++;
            if (m_arvalid !== (s_arvalid & ar_gate) || s_arready !== (m_arready & ar_gate) ||
                m_awvalid !== (s_awvalid & aw_gate) || s_awready !== (m_awready & aw_gate)) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL rand_gate c%0d: m_arv=%b s_ar=%b m_awv=%b s_aw=%b, required %b %b %b %b", c,
                             m_arvalid, s_arready, m_awvalid, s_awready,
                             s_arvalid & ar_gate, m_arready & ar_gate, s_awvalid & aw_gate, m_awready & aw_gate);
            end
            rd_inc = (s_arvalid && m_arready && ar_gate) ? 1 : 0;
            rd_dec = (rvalid && rready && rlast) ? 1 : 0;
            wr_inc = (s_awvalid && m_awready && aw_gate) ? 1 : 0;
            wr_dec = (bvalid && bready) ? 1 : 0;
            model_rd = model_rd + rd_inc - rd_dec;
            model_wr = model_wr + wr_inc - wr_dec;
            tick();
            n_tests++;
            if (rd_cnt_dbg !== CW'(model_rd) || wr_cnt_dbg !== CW'(model_wr) || busy !== 1'b0) begin
                n_fail++;
                bad++;
                if (bad < 5)
                    $display("FAIL rand_count c%0d: rd=%0d wr=%0d busy=%b, required %0d %0d 0", c,
                             rd_cnt_dbg, wr_cnt_dbg, busy, model_rd, model_wr);
            end
        end
        idle_inputs();
        reset_req = 1'b1;
        guard = 0;
        while ((model_rd > 0 || model_wr > 0) && guard < 600) begin
            rvalid = (model_rd > 0);
            rlast  = (model_rd > 0);
            bvalid = (model_wr > 0);
            tick();
            if (model_rd > 0) model_rd--;
            if (model_wr > 0) model_wr--;
            guard++;
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            if (mem_sys_reset === 1'b1) break;
            tick();
        end
        n_tests++;
        if (mem_sys_reset !== 1'b1 || rd_cnt_dbg !== 8'd0 || wr_cnt_dbg !== 8'd0) begin
            n_fail++;
            $display("FAIL rand_drain: msr=%b rd=%0d wr=%0d, required 1 0 0", mem_sys_reset, rd_cnt_dbg, wr_cnt_dbg);
        end
        recover(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rand_recover: msr=%b busy=%b, required 0 0", mem_sys_reset, busy);
        end
    endtask

    task automatic test_saturation();
        int acc;
        bit held;
        idle_inputs();
        s_arvalid = 1'b1;
        acc = 0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (s_arready !== 1'b1) break;
            acc++;
            tick();
        end
        n_tests++;
        if (acc != 255 || rd_cnt_dbg !== 8'd255 || m_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate: accepted=%0d rd_cnt=%0d m_arv=%b, required 255 255 0", acc, rd_cnt_dbg, m_arvalid);
        end
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_cnt_dbg !== 8'd255 || s_arready !== 1'b0) held = 1'b0;
        end
        n_tests++;
        if (!held) begin
            n_fail++;
            $display("FAIL saturate_hold: rd_cnt=%0d s_ar=%b, required 255 0", rd_cnt_dbg, s_arready);
        end
        s_arvalid = 1'b0;
        rvalid    = 1'b1;
        rlast     = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (rd_cnt_dbg !== 8'd254) begin
            n_fail++;
            $display("FAIL saturate_dec: rd_cnt=%0d, required 254", rd_cnt_dbg);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        idle_inputs();
        reset_req = 1'b1;
        repeat (4) tick();
`ifndef MEM_RESET_DRAIN_TIMEOUT_EN
        repeat (100) tick();
        n_tests++;
        if (drain_timeout !== 1'b0 || mem_sys_reset !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout: tmo=%b msr=%b busy=%b, required 0 0 1", drain_timeout, mem_sys_reset, busy);
        end
`endif
        reset = 1'b1;
        repeat (2) tick();
        reset     = 1'b0;
        reset_req = 1'b0;
        s_arvalid = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b1 || mem_sys_reset !== 1'b0 || cnt_error !== 1'b0 ||
            rd_cnt_dbg !== 8'd0 || m_arvalid !== 1'b0 || drain_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b msr=%b err=%b rd=%0d m_arv=%b tmo=%b, required 1 0 0 0 0 0",
                     busy, mem_sys_reset, cnt_error, rd_cnt_dbg, m_arvalid, drain_timeout);
        end
        s_arvalid = 1'b0;
        wait_run(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mid_reset_run: busy=%b, required 0", busy);
        end
        model_rd = 0;
        model_wr = 0;
    endtask

`ifdef MEM_RESET_DRAIN_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit ok;
        idle_inputs();
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        reset_req = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (mem_sys_reset === 1'b1) break;
        end
        n_tests++;
        if (n != TMO + 1 || drain_timeout !== 1'b1 || rd_cnt_dbg !== 8'd0) begin
            n_fail++;
            $display("FAIL timeout: reset after %0d edges tmo=%b rd=%0d, required %0d 1 0",
                     n, drain_timeout, rd_cnt_dbg, TMO + 1);
        end
        recover(ok);
        n_tests++;
        if (!ok || drain_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_recover: busy=%b tmo=%b, required 0 1", busy, drain_timeout);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_passthrough();
        test_read_drain();
        test_aw_hold();
        test_same_cycle_and_error();
        test_random_traffic();
        test_saturation();
        test_mid_reset();
`ifdef MEM_RESET_DRAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
